// File: rtl/mii_to_baser_66b_encoder_if.sv
// MII-side input word and packed 66b output bundle of the 64B/66B TX encoder.
// The producer drives the MII word; the encoder returns four coded blocks,
// a one-cycle valid and its running block-type counters.
interface mii_to_baser_66b_encoder_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0]  i_txd;
    logic [CTRL_WIDTH-1:0]  i_txc;
    logic                   i_valid;
    logic [FRAME_WIDTH-1:0] o_tx_coded_0;
    logic [FRAME_WIDTH-1:0] o_tx_coded_1;
    logic [FRAME_WIDTH-1:0] o_tx_coded_2;
    logic [FRAME_WIDTH-1:0] o_tx_coded_3;
    logic                   o_valid;
    logic [31:0]            o_block_count;
    logic [31:0]            o_data_count;
    logic [31:0]            o_ctrl_count;
    logic [31:0]            o_err_block_count;

    modport master (
        output i_txd, i_txc, i_valid,
        input  o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3, o_valid,
        input  o_block_count, o_data_count, o_ctrl_count, o_err_block_count
    );

    modport slave (
        input  i_txd, i_txc, i_valid,
        output o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3, o_valid,
        output o_block_count, o_data_count, o_ctrl_count, o_err_block_count
    );
endinterface

// File: rtl/mii_to_baser_66b_encoder.sv
// 1.6TMII -> 64B/66B transmit encoder. Each accepted MII word is classified,
// encoded into a 66b block under the INIT/C/D/T/E TX state machine, and the
// blocks are gathered four at a time onto the 4-lane coded output.
module mii_to_baser_66b_encoder #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    mii_to_baser_66b_encoder_if.slave bus
);
    typedef enum logic [2:0] {ST_INIT, ST_C, ST_D, ST_T, ST_E} state_t;
    typedef enum logic [2:0] {W_D, W_C, W_S, W_O, W_T, W_E} wclass_t;

    localparam logic [HDR_WIDTH-1:0]   SH_DATA = 2'b10;
    localparam logic [HDR_WIDTH-1:0]   SH_CTRL = 2'b01;
    // Error block: control type with every field set to /E/.
    localparam logic [FRAME_WIDTH-1:0] EBLOCK  = {{8{7'h1E}}, 8'h1E, SH_CTRL};
    // Local-fault ordered set sent while the link has never seen a clean start.
    localparam logic [FRAME_WIDTH-1:0] LBLOCK  = 66'h400012D;

    // 7-bit control code for an idle (07) or error (FE) character.
    function automatic logic [6:0] ctrl7(input logic [7:0] b);
        return (b == 8'hFE) ? 7'h1E : 7'h00;
    endfunction

    // Block type for a terminate in byte lane k.
    function automatic logic [7:0] t_type(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] txd;
    logic [CTRL_WIDTH-1:0] txc;
    logic [CTRL_WIDTH-1:0] cc;      // byte k is an idle/error control char
    logic [CTRL_WIDTH-1:0] t_hit;   // word is a terminate in lane k
    wclass_t               wclass;
    logic [2:0]            t_k;
    logic [FRAME_WIDTH-1:0] enc_blk;
    logic [FRAME_WIDTH-1:0] blk;
    state_t                state_q, state_d;

    logic [1:0]                       addr;
    logic [2:0][FRAME_WIDTH-1:0]      shadow;
    logic [FRAME_WIDTH-1:0]           coded_0, coded_1, coded_2, coded_3;
    logic                             out_vld;
    logic [31:0]                      block_cnt, data_cnt, ctrl_cnt, err_cnt;

    assign txd = bus.i_txd;
    assign txc = bus.i_txc;

    // Per-lane terminate detection: txc mask, FD in lane k, only 07/FE above it.
    for (genvar k = 0; k < CTRL_WIDTH; k++) begin : g_lane
        localparam logic [CTRL_WIDTH-1:0] TXC_T = {CTRL_WIDTH{1'b1}} << k;
        localparam logic [CTRL_WIDTH-1:0] HI    = {CTRL_WIDTH{1'b1}} << (k + 1);
        assign cc[k]    = (txd[8*k +: 8] == 8'h07) || (txd[8*k +: 8] == 8'hFE);
        assign t_hit[k] = (txc == TXC_T) && (txd[8*k +: 8] == 8'hFD) && ((cc & HI) == HI);
    end

    // Classify the incoming MII word.
    always_comb begin
        wclass = W_E;
        t_k    = 3'd0;
        for (int k = 0; k < CTRL_WIDTH; k++)
            if (t_hit[k]) t_k = 3'(k);
        if (txc == 8'h00)
            wclass = W_D;
        else if (txc == 8'hFF && (&cc))
            wclass = W_C;
        else if (txc == 8'h01 && txd[7:0] == 8'hFB)
            wclass = W_S;
        else if (txc == 8'hF1 && txd[7:0] == 8'h9C && txd[63:32] == 32'h0)
            wclass = W_O;
        else if (|t_hit)
            wclass = W_T;
    end

    // Encode the word as its own class would appear on the wire.
    always_comb begin
        enc_blk = '0;
        case (wclass)
            W_D: enc_blk = {txd, SH_DATA};
            W_C: begin
                enc_blk[9:0] = {8'h1E, SH_CTRL};
                for (int i = 0; i < 8; i++)
                    enc_blk[10 + 7*i +: 7] = ctrl7(txd[8*i +: 8]);
            end
            W_S: enc_blk = {txd[63:8], 8'h78, SH_CTRL};
            W_O: enc_blk = {28'h0, 4'h0, txd[31:8], 8'h4B, SH_CTRL};
            W_T: begin
                enc_blk[9:0] = {t_type(t_k), SH_CTRL};
                // Data bytes sit low, control chars keep their C-block slots
                // (MSB-packed), the gap between them stays zero.
                for (int i = 0; i < 7; i++)
                    if (3'(i) < t_k) enc_blk[10 + 8*i +: 8] = txd[8*i +: 8];
                for (int i = 1; i < 8; i++)
                    if (3'(i) > t_k) enc_blk[10 + 7*i +: 7] = ctrl7(txd[8*i +: 8]);
            end
            default: enc_blk = EBLOCK;
        endcase
    end

    // TX state register, one step per accepted word.
    always_ff @(posedge clk) begin
        if (!i_rst_n) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

    // Next state and the block actually emitted for this word.
    always_comb begin
        state_d = state_q;
        blk     = enc_blk;
        case (state_q)
            ST_INIT: begin
                if (wclass == W_C || wclass == W_O) state_d = ST_C;
                else if (wclass == W_S)             state_d = ST_D;
                else                                blk     = LBLOCK;
            end
            ST_C, ST_T: begin
                if (wclass == W_C || wclass == W_O) state_d = ST_C;
                else if (wclass == W_S)             state_d = ST_D;
                else                                state_d = ST_E;
            end
            ST_D: begin
                if (wclass == W_D)      state_d = ST_D;
                else if (wclass == W_T) state_d = ST_T;
                else                    state_d = ST_E;
            end
            ST_E: begin
                if (wclass == W_D)                       state_d = ST_D;
                else if (wclass == W_T)                  state_d = ST_T;
                else if (wclass == W_C || wclass == W_O) state_d = ST_C;
                else                                     state_d = ST_E;
            end
            default: state_d = ST_INIT;
        endcase
        // Any step that lands in E (including staying there) sends an error block.
        if (state_d == ST_E) blk = EBLOCK;
        if (!bus.i_valid) state_d = state_q;
    end

    // Slot packing, 4-lane output update and per-type counters.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            addr      <= 2'd0;
            shadow    <= '0;
            coded_0   <= '0;
            coded_1   <= '0;
            coded_2   <= '0;
            coded_3   <= '0;
            out_vld   <= 1'b0;
            block_cnt <= 32'd0;
            data_cnt  <= 32'd0;
            ctrl_cnt  <= 32'd0;
            err_cnt   <= 32'd0;
        end else begin
            out_vld <= 1'b0;
            if (bus.i_valid) begin
                addr      <= addr + 2'd1;
                block_cnt <= block_cnt + 32'd1;
                if (blk[1:0] == SH_DATA) data_cnt <= data_cnt + 32'd1;
                else                     ctrl_cnt <= ctrl_cnt + 32'd1;
                if (blk == EBLOCK)       err_cnt  <= err_cnt + 32'd1;
                case (addr)
                    2'd0: shadow[0] <= blk;
                    2'd1: shadow[1] <= blk;
                    2'd2: shadow[2] <= blk;
                    default: begin
                        coded_0 <= shadow[0];
                        coded_1 <= shadow[1];
                        coded_2 <= shadow[2];
                        coded_3 <= blk;
                        out_vld <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.o_tx_coded_0      = coded_0;
    assign bus.o_tx_coded_1      = coded_1;
    assign bus.o_tx_coded_2      = coded_2;
    assign bus.o_tx_coded_3      = coded_3;
    assign bus.o_valid           = out_vld;
    assign bus.o_block_count     = block_cnt;
    assign bus.o_data_count      = data_cnt;
    assign bus.o_ctrl_count      = ctrl_cnt;
    assign bus.o_err_block_count = err_cnt;
endmodule

// File: tb/tb_mii_to_baser_66b_encoder.sv
// Bench for the MII -> 64B/66B encoder: table of words with hand-encoded
// blocks, a group scoreboard checked on o_valid, plus reset/gap sequences.
module tb_mii_to_baser_66b_encoder;
    localparam logic [65:0] EBLK = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [65:0] LBLK = 66'h400012D;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [65:0] IDLE_E = 66'h79;
    localparam logic [63:0] S_D    = 64'hD5555555555555FB;
    localparam logic [65:0] S_E    = {56'hD5555555555555, 8'h78, 2'b01};
    localparam logic [63:0] D_D    = 64'h0123456789ABCDEF;
    localparam logic [65:0] D_E    = {64'h0123456789ABCDEF, 2'b10};
    localparam logic [63:0] T3_D   = 64'h07070707FDCCBBAA;
    localparam logic [65:0] T3_E   = {32'h0, 24'hCCBBAA, 8'hB4, 2'b01};
    localparam logic [63:0] T0_D   = 64'h07070707070707FD;
    localparam logic [65:0] T0_E   = 66'h21D;
    localparam logic [63:0] O_D    = 64'h000000003322119C;
    localparam logic [65:0] O_E    = {32'h0, 24'h332211, 8'h4B, 2'b01};
    localparam logic [63:0] T7_D   = 64'hFD66554433221100;
    localparam logic [65:0] T7_E   = {56'h66554433221100, 8'hFF, 2'b01};
    localparam logic [63:0] T5_D   = 64'h07FEFD0504030201;
    localparam logic [65:0] T5_E   = {7'h00, 7'h1E, 2'b00, 40'h0504030201, 8'hD2, 2'b01};
    localparam logic [63:0] CM_D   = 64'h07FE07FE07FE07FE;
    localparam logic [65:0] CM_E   = {7'h00, 7'h1E, 7'h00, 7'h1E, 7'h00, 7'h1E, 7'h00, 7'h1E, 8'h1E, 2'b01};
    localparam logic [63:0] BAD_D  = 64'h0707070707070755;
    localparam logic [63:0] BADT_D = 64'h07075507FDCCBBAA;

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic [65:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mii_to_baser_66b_encoder_if bus ();

    mii_to_baser_66b_encoder dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0][65:0] sb_q[$];
    logic [3:0][65:0] grp;
    int               sb_n = 0;
    logic [31:0]      m_blk, m_data, m_ctrl, m_err;
    vec_t             tbl[24];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every o_valid pulse must match the oldest complete group.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_o_valid actual=1 expected=0 at %0t", $time);
            end else begin
                logic [3:0][65:0] g;
                g = sb_q.pop_front();
                chk("lane0", bus.o_tx_coded_0, g[0]);
                chk("lane1", bus.o_tx_coded_1, g[1]);
                chk("lane2", bus.o_tx_coded_2, g[2]);
                chk("lane3", bus.o_tx_coded_3, g[3]);
            end
        end
    end

    task automatic model_clear();
        sb_n   = 0;
        m_blk  = 0;
        m_data = 0;
        m_ctrl = 0;
        m_err  = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c, input logic [65:0] e);
        bus.i_txd   = d;
        bus.i_txc   = c;
        bus.i_valid = 1'b1;
        grp[sb_n]   = e;
        sb_n++;
        if (sb_n == 4) begin
            sb_q.push_back(grp);
            sb_n = 0;
        end
        m_blk++;
        if (e[1:0] == 2'b10) m_data++;
        else                 m_ctrl++;
        if (e == EBLK)       m_err++;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Idle cycles with a data word on the bus that must not be accepted.
    task automatic gap(input int n);
        bus.i_txd   = D_D;
        bus.i_txc   = 8'h00;
        bus.i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // A completed group must have been consumed exactly one clock after its last word.
    task automatic drain();
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL o_valid_latency pending_groups=%0d expected=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_block_count"}, 66'(bus.o_block_count), 66'(m_blk));
        chk({tag, "_data_count"},  66'(bus.o_data_count),  66'(m_data));
        chk({tag, "_ctrl_count"},  66'(bus.o_ctrl_count),  66'(m_ctrl));
        chk({tag, "_err_count"},   66'(bus.o_err_block_count), 66'(m_err));
    endtask

    initial begin
        // Six groups starting from state C; comments give the state after each word.
        tbl[0]  = '{IDLE_D, 8'hFF, IDLE_E};  // C
        tbl[1]  = '{S_D,    8'h01, S_E};     // D
        tbl[2]  = '{D_D,    8'h00, D_E};     // D
        tbl[3]  = '{T3_D,   8'hF8, T3_E};    // T
        tbl[4]  = '{IDLE_D, 8'hFF, IDLE_E};  // C
        tbl[5]  = '{D_D,    8'h00, EBLK};    // E
        tbl[6]  = '{IDLE_D, 8'hFF, IDLE_E};  // C
        tbl[7]  = '{BAD_D,  8'hFF, EBLK};    // E
        tbl[8]  = '{T0_D,   8'hFF, T0_E};    // T
        tbl[9]  = '{O_D,    8'hF1, O_E};     // C
        tbl[10] = '{S_D,    8'h01, S_E};     // D
        tbl[11] = '{T7_D,   8'h80, T7_E};    // T
        tbl[12] = '{CM_D,   8'hFF, CM_E};    // C
        tbl[13] = '{S_D,    8'h01, S_E};     // D
        tbl[14] = '{S_D,    8'h01, EBLK};    // E
        tbl[15] = '{S_D,    8'h01, EBLK};    // E stays
        tbl[16] = '{D_D,    8'h00, D_E};     // D
        tbl[17] = '{T5_D,   8'hE0, T5_E};    // T
        tbl[18] = '{D_D,    8'h00, EBLK};    // E
        tbl[19] = '{T3_D,   8'hF8, T3_E};    // T
        tbl[20] = '{IDLE_D, 8'hFF, IDLE_E};  // C
        tbl[21] = '{BADT_D, 8'hF8, EBLK};    // E
        tbl[22] = '{IDLE_D, 8'hFF, IDLE_E};  // C
        tbl[23] = '{O_D,    8'hF1, O_E};     // C

        bus.i_txd   = '0;
        bus.i_txc   = '0;
        bus.i_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state.
        chk("rst_valid", 66'(bus.o_valid), 66'h0);
        chk("rst_lane0", bus.o_tx_coded_0, 66'h0);
        chk("rst_lane3", bus.o_tx_coded_3, 66'h0);
        check_counts("rst");

        // Idle x4 from INIT.
        for (int i = 0; i < 4; i++) send(IDLE_D, 8'hFF, IDLE_E);
        drain();
        check_counts("idle4");

        // Table-driven groups.
        for (int i = 0; i < 24; i++) begin
            send(tbl[i].txd, tbl[i].txc, tbl[i].exp);
            if (i % 4 == 3) begin
                drain();
                check_counts($sformatf("grp%0d", i / 4));
            end
        end

        // Data before any start after reset gives LBLOCK and stays in INIT.
        do_reset();
        send(D_D, 8'h00, LBLK);
        send(D_D, 8'h00, LBLK);
        send(IDLE_D, 8'hFF, IDLE_E);
        send(D_D, 8'h00, EBLK);
        drain();
        check_counts("lblock");

        // Reset mid-group drops the partial group.
        do_reset();
        send(IDLE_D, 8'hFF, IDLE_E);
        send(IDLE_D, 8'hFF, IDLE_E);
        do_reset();
        gap(2);
        check_counts("midrst");
        chk("midrst_lane0", bus.o_tx_coded_0, 66'h0);
        send(IDLE_D, 8'hFF, IDLE_E);
        send(S_D, 8'h01, S_E);
        send(D_D, 8'h00, D_E);
        send(T3_D, 8'hF8, T3_E);
        drain();
        check_counts("fresh");

        // Valid pattern 1,0,0,1,1,0,1: one pulse, state and slot frozen in the gaps.
        send(IDLE_D, 8'hFF, IDLE_E);
        gap(2);
        send(IDLE_D, 8'hFF, IDLE_E);
        send(IDLE_D, 8'hFF, IDLE_E);
        gap(1);
        check_counts("gap_mid");
        send(IDLE_D, 8'hFF, IDLE_E);
        drain();
        check_counts("gap_end");
        gap(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
